hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage RV32I core; the stall/flush counterpart to the forwarding path. It detects hazards that forwarding cannot resolve (load-use, taken branch/jump in EX, data-memory wait) and drives the per-stage write-enable and bubble signals. A small FSM tracks multi-cycle memory stalls with a timeout, and saturating counters record stall and flush activity.

## Interface
- MEM_TIMEOUT, 255: maximum freeze cycles on one data-memory access before error; 1..2^16-1
- CNT_W, 32: width of the performance counters
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ifid_rs1, ifid_rs2  input  5 each  source registers of the instruction in ID
- ifid_uses_rs1, ifid_uses_rs2  input  1 each  ID instruction actually reads rs1/rs2
- idex_rd  input  5  destination of the instruction in EX
- idex_mem_read  input  1  EX instruction is a load
- branch_taken  input  1  EX resolved a taken branch/jump (PC redirect)
- dmem_req  input  1  MEM-stage instruction has an outstanding data-memory access
- dmem_ready  input  1  data memory completes the access this cycle
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  stage register advances (1) or holds (0)
- ifid_flush, idex_flush, memwb_flush  output  1 each  stage register loads a bubble (NOP, wb=0)
- mem_err  output  1  sticky memory-timeout error
- stall_cycles  output  CNT_W  cycles with pc_we=0
- flush_events  output  CNT_W  branch-flush events

## Operation
- States: S_RUN, S_MEM_WAIT, S_ERR. Reset -> S_RUN, wait_cnt=0, counters=0, mem_err=0.
- Stage-control outputs are combinational from current state and inputs; the state, wait_cnt, counters and mem_err are registered.
- load_use = idex_mem_read & (idex_rd!=0) & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd)).
- mem_wait = dmem_req & !dmem_ready.
- Priority in S_RUN and S_MEM_WAIT: mem_wait > branch_taken > load_use > normal.
- Freeze (mem_wait): all five *_we=0, ifid_flush=idex_flush=0, memwb_flush=1.
- Branch: all *_we=1, ifid_flush=idex_flush=1, memwb_flush=0; flush_events+1.
- Load-use: pc_we=ifid_we=0, idex_flush=1, idex_we/exmem_we/memwb_we=1, other flushes 0.
- Normal: all *_we=1, all flushes 0.
- S_RUN with mem_wait: freeze; wait_cnt<=1; go to S_MEM_WAIT, or to S_ERR if MEM_TIMEOUT==1.
- S_MEM_WAIT with mem_wait: freeze; if wait_cnt==MEM_TIMEOUT-1 -> S_ERR, else wait_cnt+1.
- S_MEM_WAIT without mem_wait: evaluate the cycle exactly as S_RUN (branch/load-use apply); -> S_RUN, wait_cnt<=0.
- S_ERR: freeze outputs permanently, mem_err=1; only rst_n exits.
- stall_cycles +1 in every cycle with pc_we=0, including S_ERR. Both counters saturate at 2^CNT_W-1.

## Timing
- Hazard response is zero-latency: controls are valid in the same cycle the condition is present.
- Load-use costs exactly 1 bubble: after the bubble, idex_mem_read for the dependent pair is 0.
- A branch held in EX during a freeze acts on the release cycle only; flush_events increments once.
- Release cycle: dmem_ready=1 when the access completes -> the pipeline advances in the same cycle.
- Error: with ready never asserted, freeze cycles 1..MEM_TIMEOUT occur and mem_err=1 from cycle MEM_TIMEOUT+1.
- rst_n low mid-stall: state->S_RUN, counters and mem_err cleared at once; outputs follow the S_RUN rules.
- rd=x0 never causes a load-use stall.

## Test plan
- Load x5, next add uses rs2=x5 (uses_rs2=1) -> one cycle pc_we=ifid_we=0, idex_flush=1; stall_cycles=1; flush_events=0.
- Load into x0 with dependent reader x0 -> no stall; all we=1, all flushes 0.
- branch_taken for 1 cycle -> ifid_flush=idex_flush=1, all we=1; flush_events=1.
- dmem_req=1, ready low 3 cycles then high, branch_taken held -> 3 freeze cycles with memwb_flush=1; branch flush on the 4th cycle; stall_cycles=3, flush_events=1.
- MEM_TIMEOUT=4, ready never -> freeze cycles 1-4, mem_err=1 from cycle 5, state S_ERR; deassert rst_n -> mem_err=0 and counters=0.
- load_use, branch_taken and mem_wait all asserted together -> freeze only; then branch only when ready rises.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use bubbles, branch flushes,
// data-memory freezes with a timeout error state, and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_ERR      = 2'd2;

  localparam logic [15:0]      TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [1:0]       FIRST_WAIT_STATE = (MEM_TIMEOUT == 1) ? S_ERR : S_MEM_WAIT;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [15:0]      wait_cnt_r;
  logic [15:0]      wait_cnt_nxt_s;
  logic             mem_err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             load_use_s;
  logic             mem_wait_s;
  logic             freeze_s;
  logic             branch_s;
  logic             bubble_s;

  assign load_use_s = idex_mem_read & (idex_rd != 5'd0) &
                      ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
                       (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));
  assign mem_wait_s = dmem_req & ~dmem_ready;

  // Hazard priority and next-state decode; an unknown state is treated as a fault.
  always_comb begin
    freeze_s       = 1'b0;
    branch_s       = 1'b0;
    bubble_s       = 1'b0;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      S_RUN, S_MEM_WAIT: begin
        if (mem_wait_s) begin
          freeze_s = 1'b1;
          if (state_r == S_RUN) begin
            wait_cnt_nxt_s = 16'd1;
            state_nxt_s    = FIRST_WAIT_STATE;
          end else if (wait_cnt_r == TIMEOUT_LAST) begin
            state_nxt_s = S_ERR;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + 16'd1;
          end
        end else begin
          // Release from a wait is evaluated exactly like a running cycle.
          branch_s       = branch_taken;
          bubble_s       = ~branch_taken & load_use_s;
          wait_cnt_nxt_s = 16'd0;
          state_nxt_s    = S_RUN;
        end
      end
      S_ERR: begin
        freeze_s = 1'b1;
      end
      default: begin
        freeze_s    = 1'b1;
        state_nxt_s = S_ERR;
      end
    endcase
  end

  assign pc_we        = ~(freeze_s | bubble_s);
  assign ifid_we      = ~(freeze_s | bubble_s);
  assign idex_we      = ~freeze_s;
  assign exmem_we     = ~freeze_s;
  assign memwb_we     = ~freeze_s;
  assign ifid_flush   = branch_s;
  assign idex_flush   = branch_s | bubble_s;
  assign memwb_flush  = freeze_s;
  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_cnt_r;
  assign flush_events = flush_cnt_r;

  // State, wait counter, sticky error and saturating activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_RUN;
      wait_cnt_r  <= 16'd0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= (state_nxt_s == S_ERR);
      if (!pc_we && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (branch_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a cycle-level model checks every cycle on the
// falling edge, and literal expectations pin each directed scenario.
module tb_hazard_ctrl_unit;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [7:0] ST_NORMAL = 8'b11111_000;
  localparam logic [7:0] ST_FREEZE = 8'b00000_001;
  localparam logic [7:0] ST_BRANCH = 8'b11111_110;
  localparam logic [7:0] ST_BUBBLE = 8'b00111_010;

  logic          clk;
  logic          rst_n;
  logic [4:0]    ifid_rs1, ifid_rs2, idex_rd;
  logic          ifid_uses_rs1, ifid_uses_rs2, idex_mem_read;
  logic          branch_taken, dmem_req, dmem_ready;
  logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic          ifid_flush, idex_flush, memwb_flush, mem_err;
  logic [CW-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive memory-wait cycles, error flag, counters.
  int m_run = 0;
  bit m_err = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_ctrl_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] stage_vec();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, memwb_flush};
  endfunction

  // Per-cycle model check on the falling edge, then advance the model past the next rise.
  always @(negedge clk) begin
    bit lu, mw, frz, br, bub;
    logic [7:0] exp_stage;
    if (!rst_n) begin
      m_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end
    lu  = idex_mem_read && (idex_rd != 5'd0) &&
          ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd));
    mw  = dmem_req && !dmem_ready;
    frz = m_err || mw;
    br  = !frz && branch_taken;
    bub = !frz && !br && lu;
    if (frz)      exp_stage = ST_FREEZE;
    else if (br)  exp_stage = ST_BRANCH;
    else if (bub) exp_stage = ST_BUBBLE;
    else          exp_stage = ST_NORMAL;
    check("model_stage", int'(stage_vec()), int'(exp_stage));
    check("model_mem_err", int'(mem_err), int'(m_err));
    check("model_stall", int'(stall_cycles), m_stall);
    check("model_flush", int'(flush_events), m_flush);
    if (rst_n) begin
      if (frz || bub) m_stall = (m_stall < CMAX) ? m_stall + 1 : m_stall;
      if (br)         m_flush = (m_flush < CMAX) ? m_flush + 1 : m_flush;
      if (!m_err && mw) begin
        m_run = m_run + 1;
        if (m_run >= TO) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
    ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    cyc(); rst_n = 1'b0; idle();
    cyc(); rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    idle();
    repeat (2) cyc();
    #2;
    check("rst_stage", int'(stage_vec()), int'(ST_NORMAL));
    check("rst_stall", int'(stall_cycles), 0);
    check("rst_mem_err", int'(mem_err), 0);
    cyc(); rst_n = 1'b1;

    // Load x5 followed by a reader of x5 through rs2.
    cyc();
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd3; ifid_uses_rs1 = 1'b1;
    ifid_rs2 = 5'd5; ifid_uses_rs2 = 1'b1;
    #2 check("lu_stage", int'(stage_vec()), int'(ST_BUBBLE));
    cyc(); idle();
    #2 check("lu_after_stage", int'(stage_vec()), int'(ST_NORMAL));
    check("lu_stall", int'(stall_cycles), 1);
    check("lu_flush", int'(flush_events), 0);

    // Load into x0 never stalls.
    cyc();
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_uses_rs1 = 1'b1;
    #2 check("x0_stage", int'(stage_vec()), int'(ST_NORMAL));
    cyc(); idle();
    #2 check("x0_stall", int'(stall_cycles), 1);

    // Single-cycle taken branch.
    cyc(); branch_taken = 1'b1;
    #2 check("br_stage", int'(stage_vec()), int'(ST_BRANCH));
    cyc(); idle();
    #2 check("br_flush", int'(flush_events), 1);

    // Three-cycle memory wait with a branch held in EX.
    do_reset();
    cyc(); dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 check("mw_freeze", int'(stage_vec()), int'(ST_FREEZE));
      cyc();
    end
    dmem_ready = 1'b1;
    #2 check("mw_release", int'(stage_vec()), int'(ST_BRANCH));
    cyc(); idle();
    #2 check("mw_stall", int'(stall_cycles), 3);
    check("mw_flush", int'(flush_events), 1);
    check("mw_no_err", int'(mem_err), 0);

    // Load-use, branch and memory wait together.
    do_reset();
    cyc();
    idex_mem_read = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_uses_rs1 = 1'b1;
    branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #2 check("all_freeze", int'(stage_vec()), int'(ST_FREEZE));
    cyc(); dmem_ready = 1'b1;
    #2 check("all_release", int'(stage_vec()), int'(ST_BRANCH));
    cyc(); idle();
    #2 check("all_flush", int'(flush_events), 1);
    check("all_stall", int'(stall_cycles), 1);

    // Memory timeout, sticky error, counter saturation and asynchronous reset.
    do_reset();
    cyc(); dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #2 check("to_no_err", int'(mem_err), 0);
      cyc();
    end
    #2 check("to_err", int'(mem_err), 1);
    check("to_err_stage", int'(stage_vec()), int'(ST_FREEZE));
    cyc(); idle(); branch_taken = 1'b1;
    #2 check("err_sticky_stage", int'(stage_vec()), int'(ST_FREEZE));
    repeat (15) cyc();
    #2 check("stall_sat", int'(stall_cycles), CMAX);
    check("err_flush", int'(flush_events), 0);
    cyc(); rst_n = 1'b0;
    #2 check("arst_mem_err", int'(mem_err), 0);
    check("arst_stall", int'(stall_cycles), 0);
    check("arst_stage", int'(stage_vec()), int'(ST_BRANCH));
    cyc(); rst_n = 1'b1; idle();
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
